// File: rtl/jtag_debug_scan_master.sv
// Virtual-JTAG scan master: runs one UIR/CDR/SDR/UDR/RTI sequence per command
// with a tck derived from clk, and returns the captured tdo bits.
module jtag_debug_scan_master #(
    parameter int unsigned TCK_DIV  = 2,
    parameter int unsigned SR_WIDTH = 38
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [SR_WIDTH-1:0] rsp_data,
    output logic [1:0]          rsp_ir_out,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_udr,
    output logic                vji_rti,
    output logic [1:0]          vji_ir_in,
    input  logic                vji_tdo,
    input  logic [1:0]          vji_ir_out,
    output logic                busy
);

    localparam int unsigned PERIOD = 2 * TCK_DIV;
    localparam int unsigned CNT_W  = $clog2(PERIOD);
    localparam int unsigned BIT_W  = (SR_WIDTH > 1) ? $clog2(SR_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_UIR, S_CDR, S_SDR, S_UDR, S_RTI, S_RESP
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt, bit_nxt;
    logic [SR_WIDTH-1:0] data_q, data_nxt, data_shr;
    logic [SR_WIDTH-1:0] rsp_data_nxt;
    logic [1:0]          rsp_ir_nxt, ir_in_nxt;
    logic                tdi_nxt, tck_nxt;
    logic                period_end, tck_rise, scan_nxt;

    // State, counters and all outputs are registered from their next values
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            data_q     <= '0;
            rsp_data   <= '0;
            rsp_ir_out <= '0;
            vji_ir_in  <= '0;
            vji_tdi    <= 1'b0;
            vji_tck    <= 1'b0;
            vji_uir    <= 1'b0;
            vji_cdr    <= 1'b0;
            vji_sdr    <= 1'b0;
            vji_udr    <= 1'b0;
            vji_rti    <= 1'b1;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_nxt;
            data_q     <= data_nxt;
            rsp_data   <= rsp_data_nxt;
            rsp_ir_out <= rsp_ir_nxt;
            vji_ir_in  <= ir_in_nxt;
            vji_tdi    <= tdi_nxt;
            vji_tck    <= tck_nxt;
            vji_uir    <= (state_nxt == S_UIR);
            vji_cdr    <= (state_nxt == S_CDR);
            vji_sdr    <= (state_nxt == S_SDR);
            vji_udr    <= (state_nxt == S_UDR);
            vji_rti    <= (state_nxt == S_IDLE) || (state_nxt == S_RTI);
            cmd_ready  <= (state_nxt == S_IDLE);
            rsp_valid  <= (state_nxt == S_RESP);
            busy       <= (state_nxt != S_IDLE);
        end
    end

    // Next-state, tck phase, tdi shift-out and tdo/ir_out capture
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_nxt      = bit_cnt;
        data_nxt     = data_q;
        rsp_data_nxt = rsp_data;
        rsp_ir_nxt   = rsp_ir_out;
        ir_in_nxt    = vji_ir_in;
        tdi_nxt      = vji_tdi;
        data_shr     = data_q >> 1;
        period_end   = (cnt == CNT_W'(PERIOD - 1));
        tck_rise     = (cnt == CNT_W'(TCK_DIV - 1));

        if ((state != S_IDLE) && (state != S_RESP)) begin
            cnt_nxt = period_end ? '0 : cnt + 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    state_nxt = S_UIR;
                    data_nxt  = cmd_data;
                    ir_in_nxt = cmd_ir;
                    cnt_nxt   = '0;
                    bit_nxt   = '0;
                end
            end
            S_UIR: begin
                if (period_end) state_nxt = S_CDR;
            end
            S_CDR: begin
                if (tck_rise) rsp_ir_nxt = vji_ir_out;
                if (period_end) begin
                    state_nxt = S_SDR;
                    tdi_nxt   = data_q[0];
                end
            end
            S_SDR: begin
                // tdo bits enter at the MSB so bit k lands at index k after the last shift
                if (tck_rise) rsp_data_nxt = {vji_tdo, rsp_data[SR_WIDTH-1:1]};
                if (period_end) begin
                    if (bit_cnt == BIT_W'(SR_WIDTH - 1)) begin
                        state_nxt = S_UDR;
                        bit_nxt   = '0;
                        tdi_nxt   = 1'b0;
                    end else begin
                        bit_nxt  = bit_cnt + 1'b1;
                        data_nxt = data_shr;
                        tdi_nxt  = data_shr[0];
                    end
                end
            end
            S_UDR: begin
                if (period_end) state_nxt = S_RTI;
            end
            S_RTI: begin
                if (period_end) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        scan_nxt = (state_nxt != S_IDLE) && (state_nxt != S_RESP);
        tck_nxt  = scan_nxt && (cnt_nxt >= CNT_W'(TCK_DIV));
    end

endmodule

// File: doc/jtag_debug_scan_master.md
JTAG_DEBUG_SCAN_MASTER -- requirements
Module: jtag_debug_scan_master

Interface
REQ-001 SHALL have parameter TCK_DIV, default 2: number of clk cycles per tck half-period; legal range 1..255.
REQ-002 SHALL have parameter SR_WIDTH, default 38: number of scan bits per data phase.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid, input, 1 bit: a command is offered.
REQ-006 SHALL have port cmd_ready, output, 1 bit: the block can accept a command.
REQ-007 SHALL have port cmd_ir, input, 2 bits: virtual IR value for the scan.
REQ-008 SHALL have port cmd_data, input, SR_WIDTH bits: data shifted out, LSB first.
REQ-009 SHALL have port rsp_valid, output, 1 bit: a scan result is available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-011 SHALL have port rsp_data, output, SR_WIDTH bits: captured tdo bits.
REQ-012 SHALL have port rsp_ir_out, output, 2 bits: vji_ir_out sampled during the CDR state.
REQ-013 SHALL have ports vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr and vji_rti, outputs, 1 bit each: virtual-JTAG strobes toward the debug-module tck/sysclk pair.
REQ-014 SHALL have port vji_ir_in, output, 2 bits: virtual IR presented to the target.
REQ-015 SHALL have port vji_tdo, input, 1 bit: target serial data out.
REQ-016 SHALL have port vji_ir_out, input, 2 bits: target IR status.
REQ-017 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-018 SHALL implement the state sequence IDLE -> UIR -> CDR -> SDR -> UDR -> RTI -> RESP -> IDLE.
REQ-019 SHALL accept a command on a clk edge with cmd_valid=1 and cmd_ready=1, and SHALL then latch cmd_ir and cmd_data and enter UIR on that edge.
REQ-020 SHALL drive cmd_ready=1 only in IDLE; cmd_valid in any other state is ignored.
REQ-021 SHALL generate vji_tck from a clk counter: low for TCK_DIV clk cycles, then high for TCK_DIV clk cycles, for one period of 2*TCK_DIV clk cycles.
REQ-022 SHALL start each tck period low at state entry, and SHALL hold vji_tck=0 in IDLE and RESP.
REQ-023 SHALL hold each of UIR, CDR, UDR and RTI for exactly one tck period.
REQ-024 SHALL hold SDR for exactly SR_WIDTH tck periods, using a bit counter that runs 0..SR_WIDTH-1.
REQ-025 SHALL assert strobe vji_uir, vji_cdr, vji_sdr or vji_udr for the whole time its state is active, and SHALL hold it low otherwise.
REQ-026 SHALL assert vji_rti in IDLE and RTI, and SHALL hold it low otherwise.
REQ-027 SHALL drive vji_ir_in from the latched cmd_ir, starting at UIR entry and holding until the next accepted command.
REQ-028 SHALL update vji_tdi only at the start of a tck period (tck falling edge); in SDR period k it carries latched cmd_data[k], and outside SDR vji_tdi=0.
REQ-029 SHALL sample vji_tdo in the clk cycle where vji_tck goes 0->1 and store it as rsp_data[k] for SDR period k.
REQ-030 SHALL sample vji_ir_out at the CDR tck rising edge into rsp_ir_out.
REQ-031 SHALL make the transition of the final RTI clk cycle enter RESP with rsp_valid=1, exactly 2*TCK_DIV*(SR_WIDTH+4) clk cycles after the accept edge.
REQ-032 SHALL hold rsp_valid, rsp_data and rsp_ir_out stable in RESP until rsp_ready=1, and SHALL return to IDLE on that edge.
REQ-033 SHALL allow back-to-back operation: a command accepted on the edge after RESP exits starts a new scan with no further idle cycles.
REQ-034 SHALL treat rsp_ready outside RESP as a don't-care.
REQ-035 SHALL leave rsp_data and rsp_ir_out unchanged outside SDR and CDR sampling, so they keep the last result.

Reset
REQ-036 SHALL, while reset=1 and asynchronously, force state to IDLE, vji_tck=0, vji_tdi=0, vji_uir/cdr/sdr/udr=0, vji_rti=1, vji_ir_in=0, cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_ir_out=0, busy=0, and clear all counters.
REQ-037 SHALL, on reset in mid-scan, discard the partial scan and produce no response; the first command after release starts a clean UIR.

Verification
REQ-038 SHALL verify loopback: TCK_DIV=2, vji_tdo=vji_tdi, cmd_ir=2'b01, cmd_data=38'h2A_5A5A_5A5A -> rsp_data=38'h2A_5A5A_5A5A, rsp_valid exactly 168 clks after accept, vji_ir_in=2'b01.
REQ-039 SHALL verify strobe counting: one scan -> vji_uir, vji_cdr and vji_udr each high for 4 clks, vji_sdr high for 152 clks, 38 rising vji_tck edges during SDR and 42 in total.
REQ-040 SHALL verify backpressure: rsp_ready=0 for 20 clks after rsp_valid -> rsp_data stable, cmd_ready=0, busy=1; rsp_ready=1 -> IDLE next edge.
REQ-041 SHALL verify tdo constant 1 with vji_ir_out=2'b10 -> rsp_data=38'h3F_FFFF_FFFF, rsp_ir_out=2'b10.
REQ-042 SHALL verify reset mid-scan: reset pulsed at SDR bit 10 -> all outputs at reset values immediately, no rsp_valid; the next command completes normally.
REQ-043 SHALL verify TCK_DIV=1: loopback of 38'h00_0000_0001 -> the response equals the input after 84 clks.
